// File: rtl/reorder_buffer.sv
// reorder_buffer
// In-order retirement buffer between rename/dispatch and the free pool.
// Entries are allocated at the tail and marked done by writeback. Up to
// COMMIT_WIDTH consecutive done entries retire from the head each cycle.
// Each retired entry that wrote rd returns its old physical register to the free pool.
// Optional feature: define ROB_EXCEPTION_EN to add excepting writebacks.
// An excepting entry stops retirement when it reaches the head and reports its pc.
// It then clears the buffer on the following edge.
module reorder_buffer #(
    parameter int  DEPTH        = 16,
    parameter int  PREG_WIDTH   = 6,
    parameter int  AREG_WIDTH   = 5,
    parameter int  PC_WIDTH     = 12,
    parameter int  WB_PORTS     = 3,
    parameter int  COMMIT_WIDTH = 2,
    localparam int IDXW         = $clog2(DEPTH)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               disp_valid,
    output logic                               disp_ready,
    input  logic                               disp_reg_write,
    input  logic [AREG_WIDTH-1:0]              disp_areg,
    input  logic [PREG_WIDTH-1:0]              disp_preg,
    input  logic [PREG_WIDTH-1:0]              disp_old_preg,
    input  logic [PC_WIDTH-1:0]                disp_pc,
    output logic [IDXW-1:0]                    disp_rob_num,
    input  logic [WB_PORTS-1:0]                wb_valid,
    input  logic [WB_PORTS*IDXW-1:0]           wb_rob_num,
    output logic [COMMIT_WIDTH-1:0]            cmt_valid,
    output logic [COMMIT_WIDTH-1:0]            cmt_reg_write,
    output logic [COMMIT_WIDTH*AREG_WIDTH-1:0] cmt_areg,
    output logic [COMMIT_WIDTH*PREG_WIDTH-1:0] cmt_preg,
    output logic [COMMIT_WIDTH-1:0]            free_push,
    output logic [COMMIT_WIDTH*PREG_WIDTH-1:0] free_preg,
    input  logic                               flush,
`ifdef ROB_EXCEPTION_EN
    input  logic [WB_PORTS-1:0]                wb_exc,
    output logic                               exc_valid,
    output logic [PC_WIDTH-1:0]                exc_pc,
`endif
    output logic [IDXW:0]                      count,
    output logic                               empty,
    output logic                               full
);

    // Pointers carry an extra wrap bit so full and empty are distinguishable
    logic [IDXW:0]           head;
    logic [IDXW:0]           tail;
    logic [IDXW-1:0]         head_idx;
    logic [IDXW-1:0]         tail_idx;

    // Per-entry status and payload
    logic [DEPTH-1:0]        ent_valid;
    logic [DEPTH-1:0]        ent_done;
    logic [DEPTH-1:0]        ent_reg_write;
    logic [DEPTH-1:0]        ent_blocked;
    logic [AREG_WIDTH-1:0]   ent_areg     [DEPTH];
    logic [PREG_WIDTH-1:0]   ent_preg     [DEPTH];
    logic [PREG_WIDTH-1:0]   ent_old_preg [DEPTH];

    // Decoded writeback tags and the retirement window
    logic [IDXW-1:0]         wb_idx  [WB_PORTS];
    logic [IDXW-1:0]         ret_idx [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0] ret_mask;
    logic [IDXW:0]           ret_cnt;
    logic                    ret_run;

    logic                    accept;
    logic                    clear_all;

`ifdef ROB_EXCEPTION_EN
    logic [DEPTH-1:0]        ent_exc;
    logic [PC_WIDTH-1:0]     ent_pc [DEPTH];
    logic                    exc_pending;
    logic                    exc_hit;

    assign ent_blocked = ent_exc;
    assign clear_all   = flush | exc_pending;
    assign exc_hit     = ent_valid[head_idx] & ent_done[head_idx] & ent_exc[head_idx] & ~exc_pending;
`else
    assign ent_blocked = '0;
    assign clear_all   = flush;
`endif

    assign head_idx     = head[IDXW-1:0];
    assign tail_idx     = tail[IDXW-1:0];
    assign full         = ((head ^ tail) == {1'b1, {IDXW{1'b0}}});
    assign empty        = (count == '0);
    assign disp_ready   = ~full;
    assign disp_rob_num = tail_idx;
    assign accept       = disp_valid & disp_ready;
    assign free_push    = cmt_valid & cmt_reg_write;

    // Split the packed writeback tag bus into one index per port
    always_comb begin
        for (int p = 0; p < WB_PORTS; p++) begin
            wb_idx[p] = wb_rob_num[p*IDXW +: IDXW];
        end
    end

    // Entry indices of the retirement window, wrapping around the array
    always_comb begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            ret_idx[i] = head_idx + IDXW'(i);
        end
    end

    // Count the run of done entries from head; the first not-ready entry ends it
    always_comb begin
        ret_mask = '0;
        ret_cnt  = '0;
        ret_run  = 1'b1;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            ret_run = ret_run & ent_valid[ret_idx[i]] & ent_done[ret_idx[i]]
                      & ~ent_blocked[ret_idx[i]];
            ret_mask[i] = ret_run;
            if (ret_run) begin
                ret_cnt = ret_cnt + {{IDXW{1'b0}}, 1'b1};
            end
        end
    end

    // Pointers, status bits and registered commit lanes; clearing beats everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            ent_valid     <= '0;
            ent_done      <= '0;
            cmt_valid     <= '0;
            cmt_reg_write <= '0;
            cmt_areg      <= '0;
            cmt_preg      <= '0;
            free_preg     <= '0;
`ifdef ROB_EXCEPTION_EN
            ent_exc       <= '0;
            exc_pending   <= 1'b0;
            exc_valid     <= 1'b0;
            exc_pc        <= '0;
`endif
        end else if (clear_all) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            ent_valid     <= '0;
            ent_done      <= '0;
            cmt_valid     <= '0;
            cmt_reg_write <= '0;
            cmt_areg      <= '0;
            cmt_preg      <= '0;
            free_preg     <= '0;
`ifdef ROB_EXCEPTION_EN
            ent_exc       <= '0;
            exc_pending   <= 1'b0;
            exc_valid     <= 1'b0;
            exc_pc        <= '0;
`endif
        end else begin
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_valid[p] && ent_valid[wb_idx[p]]) begin
                    ent_done[wb_idx[p]] <= 1'b1;
`ifdef ROB_EXCEPTION_EN
                    if (wb_exc[p]) begin
                        ent_exc[wb_idx[p]] <= 1'b1;
                    end
`endif
                end
            end
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (ret_mask[i]) begin
                    ent_valid[ret_idx[i]] <= 1'b0;
                    ent_done[ret_idx[i]]  <= 1'b0;
                end
            end
            if (accept) begin
                ent_valid[tail_idx] <= 1'b1;
                ent_done[tail_idx]  <= 1'b0;
`ifdef ROB_EXCEPTION_EN
                ent_exc[tail_idx]   <= 1'b0;
`endif
            end
            head  <= head + ret_cnt;
            tail  <= tail + {{IDXW{1'b0}}, accept};
            count <= count + {{IDXW{1'b0}}, accept} - ret_cnt;
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                cmt_valid[i]     <= ret_mask[i];
                cmt_reg_write[i] <= ret_mask[i] & ent_reg_write[ret_idx[i]];
                cmt_areg[i*AREG_WIDTH +: AREG_WIDTH] <=
                    ret_mask[i] ? ent_areg[ret_idx[i]] : '0;
                cmt_preg[i*PREG_WIDTH +: PREG_WIDTH] <=
                    ret_mask[i] ? ent_preg[ret_idx[i]] : '0;
                free_preg[i*PREG_WIDTH +: PREG_WIDTH] <=
                    (ret_mask[i] && ent_reg_write[ret_idx[i]]) ? ent_old_preg[ret_idx[i]] : '0;
            end
`ifdef ROB_EXCEPTION_EN
            exc_valid <= exc_hit;
            exc_pc    <= exc_hit ? ent_pc[head_idx] : '0;
            if (exc_hit) begin
                exc_pending <= 1'b1;
            end
`endif
        end
    end

    // Payload capture on accepted dispatch; status bits decide whether it is live
    always_ff @(posedge clk) begin
        if (accept) begin
            ent_reg_write[tail_idx] <= disp_reg_write;
            ent_areg[tail_idx]      <= disp_areg;
            ent_preg[tail_idx]      <= disp_preg;
            ent_old_preg[tail_idx]  <= disp_old_preg;
`ifdef ROB_EXCEPTION_EN
            ent_pc[tail_idx]        <= disp_pc;
`endif
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer
// Random and directed stimulus for reorder_buffer.
// Expected results come from a queue model of in-flight instructions.
module tb_reorder_buffer;

    localparam int DEPTH        = 16;
    localparam int PREG_WIDTH   = 6;
    localparam int AREG_WIDTH   = 5;
    localparam int PC_WIDTH     = 12;
    localparam int WB_PORTS     = 3;
    localparam int COMMIT_WIDTH = 2;
    localparam int IDXW         = 4;

    logic                               clk;
    logic                               rst;
    logic                               disp_valid;
    logic                               disp_ready;
    logic                               disp_reg_write;
    logic [AREG_WIDTH-1:0]              disp_areg;
    logic [PREG_WIDTH-1:0]              disp_preg;
    logic [PREG_WIDTH-1:0]              disp_old_preg;
    logic [PC_WIDTH-1:0]                disp_pc;
    logic [IDXW-1:0]                    disp_rob_num;
    logic [WB_PORTS-1:0]                wb_valid;
    logic [WB_PORTS*IDXW-1:0]           wb_rob_num;
    logic [COMMIT_WIDTH-1:0]            cmt_valid;
    logic [COMMIT_WIDTH-1:0]            cmt_reg_write;
    logic [COMMIT_WIDTH*AREG_WIDTH-1:0] cmt_areg;
    logic [COMMIT_WIDTH*PREG_WIDTH-1:0] cmt_preg;
    logic [COMMIT_WIDTH-1:0]            free_push;
    logic [COMMIT_WIDTH*PREG_WIDTH-1:0] free_preg;
    logic                               flush;
    logic [IDXW:0]                      count;
    logic                               empty;
    logic                               full;
`ifdef ROB_EXCEPTION_EN
    logic [WB_PORTS-1:0]                wb_exc;
    logic                               exc_valid;
    logic [PC_WIDTH-1:0]                exc_pc;
`endif

    typedef struct {
        int tag;
        bit rw;
        int areg;
        int preg;
        int oldp;
        int pc;
        bit done;
    } rob_entry_t;

    rob_entry_t model_q[$];
    int tail_tag;
    int total;
    int bad;
    int accepted_total;
    int retired_total;

    reorder_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .disp_valid     (disp_valid),
        .disp_ready     (disp_ready),
        .disp_reg_write (disp_reg_write),
        .disp_areg      (disp_areg),
        .disp_preg      (disp_preg),
        .disp_old_preg  (disp_old_preg),
        .disp_pc        (disp_pc),
        .disp_rob_num   (disp_rob_num),
        .wb_valid       (wb_valid),
        .wb_rob_num     (wb_rob_num),
        .cmt_valid      (cmt_valid),
        .cmt_reg_write  (cmt_reg_write),
        .cmt_areg       (cmt_areg),
        .cmt_preg       (cmt_preg),
        .free_push      (free_push),
        .free_preg      (free_preg),
        .flush          (flush),
`ifdef ROB_EXCEPTION_EN
        .wb_exc         (wb_exc),
        .exc_valid      (exc_valid),
        .exc_pc         (exc_pc),
`endif
        .count          (count),
        .empty          (empty),
        .full           (full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value with its expected value
    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    // Put a writeback for one tag on one port
    task automatic setWb(input int port, input int tag);
        wb_valid[port] = 1'b1;
        wb_rob_num[port*IDXW +: IDXW] = IDXW'(tag);
    endtask

    // Random writebacks: mostly live tags, sometimes arbitrary ones
    task automatic setRandomWb();
        for (int p = 0; p < WB_PORTS; p++) begin
            if (model_q.size() > 0 && $urandom_range(0, 99) < 40) begin
                setWb(p, model_q[$urandom_range(0, model_q.size() - 1)].tag);
            end else if ($urandom_range(0, 9) == 0) begin
                setWb(p, int'($urandom_range(0, DEPTH - 1)));
            end
        end
    endtask

    // Drive one cycle, advance the model across the edge and check all outputs.
    // Called at posedge+1; returns at the following posedge+1.
    task automatic applyStimulus(input bit dv, input bit fl);
        int k;
        bit acc;
        logic [COMMIT_WIDTH-1:0]            e_valid;
        logic [COMMIT_WIDTH-1:0]            e_rw;
        logic [COMMIT_WIDTH*AREG_WIDTH-1:0] e_areg;
        logic [COMMIT_WIDTH*PREG_WIDTH-1:0] e_preg;
        logic [COMMIT_WIDTH*PREG_WIDTH-1:0] e_free;
        disp_valid     = dv;
        flush          = fl;
        disp_reg_write = 1'($urandom_range(0, 1));
        disp_areg      = AREG_WIDTH'($urandom);
        disp_preg      = PREG_WIDTH'($urandom);
        disp_old_preg  = PREG_WIDTH'($urandom);
        disp_pc        = PC_WIDTH'($urandom);
        #1;
        checkOutput("disp_ready", disp_ready, model_q.size() < DEPTH);
        checkOutput("disp_rob_num", disp_rob_num, tail_tag);
        e_valid = '0;
        e_rw    = '0;
        e_areg  = '0;
        e_preg  = '0;
        e_free  = '0;
        if (fl) begin
            model_q.delete();
            tail_tag = 0;
        end else begin
            k = 0;
            while (k < COMMIT_WIDTH && k < model_q.size() && model_q[k].done) k++;
            for (int i = 0; i < k; i++) begin
                e_valid[i] = 1'b1;
                e_rw[i]    = model_q[i].rw;
                e_areg[i*AREG_WIDTH +: AREG_WIDTH] = AREG_WIDTH'(model_q[i].areg);
                e_preg[i*PREG_WIDTH +: PREG_WIDTH] = PREG_WIDTH'(model_q[i].preg);
                if (model_q[i].rw) e_free[i*PREG_WIDTH +: PREG_WIDTH] = PREG_WIDTH'(model_q[i].oldp);
            end
            acc = dv && (model_q.size() < DEPTH);
            repeat (k) void'(model_q.pop_front());
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_valid[p]) begin
                    foreach (model_q[j]) begin
                        if (model_q[j].tag == int'(wb_rob_num[p*IDXW +: IDXW])) model_q[j].done = 1'b1;
                    end
                end
            end
            if (acc) begin
                model_q.push_back('{tag: tail_tag, rw: disp_reg_write, areg: int'(disp_areg),
                                    preg: int'(disp_preg), oldp: int'(disp_old_preg),
                                    pc: int'(disp_pc), done: 1'b0});
                tail_tag = (tail_tag + 1) % DEPTH;
                accepted_total++;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("cmt_valid", cmt_valid, e_valid);
        checkOutput("cmt_reg_write", cmt_reg_write, e_rw);
        checkOutput("free_push", free_push, e_rw);
        checkOutput("cmt_areg", cmt_areg, e_areg);
        checkOutput("cmt_preg", cmt_preg, e_preg);
        checkOutput("free_preg", free_preg, e_free);
        checkOutput("count", count, model_q.size());
        checkOutput("empty", empty, model_q.size() == 0);
        checkOutput("full", full, model_q.size() == DEPTH);
        retired_total += $countones(cmt_valid);
        disp_valid = 1'b0;
        flush      = 1'b0;
        wb_valid   = '0;
    endtask

    // Keep the run bounded even if the design stops responding
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Test sequence
    initial begin
        int acc_before;
        int ret_before;
        int pc0;
        total          = 0;
        bad            = 0;
        tail_tag       = 0;
        accepted_total = 0;
        retired_total  = 0;
        rst            = 1'b0;
        disp_valid     = 1'b0;
        disp_reg_write = 1'b0;
        disp_areg      = '0;
        disp_preg      = '0;
        disp_old_preg  = '0;
        disp_pc        = '0;
        wb_valid       = '0;
        wb_rob_num     = '0;
        flush          = 1'b0;
`ifdef ROB_EXCEPTION_EN
        wb_exc         = '0;
`endif

        // Reset state
        #3;
        checkOutput("rst_count", count, 0);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_disp_ready", disp_ready, 1);
        checkOutput("rst_cmt_valid", cmt_valid, 0);
        checkOutput("rst_free_push", free_push, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Fill to full with no writeback, then one refused dispatch
        $display("[TB] fill to full");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("fill_full", full, 1);
        checkOutput("fill_ready", disp_ready, 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("fill_rob_num", disp_rob_num, 0);
        checkOutput("fill_count", count, DEPTH);

        // Full with head done: dispatch refused while two retire, accepted next cycle
        $display("[TB] full with retirement");
        setWb(0, 0);
        setWb(1, 1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t5_count14", count, DEPTH - 2);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t5_count15", count, DEPTH - 1);
        applyStimulus(1'b0, 1'b1);

        // Out-of-order writeback, in-order retirement
        $display("[TB] reverse writeback");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
        setWb(0, 2);
        applyStimulus(1'b0, 1'b0);
        setWb(1, 1);
        applyStimulus(1'b0, 1'b0);
        setWb(2, 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("t3_hold", cmt_valid, 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("t3_pair", cmt_valid, 2'b11);
        applyStimulus(1'b0, 1'b0);
        checkOutput("t3_last", cmt_valid, 2'b01);

        // Flush with five entries plus same-cycle dispatch and writeback
        $display("[TB] flush");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
        setWb(0, model_q[0].tag);
        setWb(1, model_q[1].tag);
        applyStimulus(1'b1, 1'b1);
        checkOutput("t6_empty", empty, 1);
        checkOutput("t6_count", count, 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("t6_no_commit", cmt_valid, 0);

        // Random traffic wrapping the array several times
        $display("[TB] random traffic");
        acc_before = accepted_total;
        ret_before = retired_total;
        for (int c = 0; c < 2000 && (accepted_total - acc_before) < 40; c++) begin
            setRandomWb();
            applyStimulus($urandom_range(0, 99) < 60, 1'b0);
        end
        checkOutput("t4_dispatched", (accepted_total - acc_before) >= 40, 1);
        for (int c = 0; c < 400 && count != 0; c++) begin
            for (int p = 0; p < WB_PORTS; p++) begin
                if (model_q.size() > 0) setWb(p, model_q[$urandom_range(0, model_q.size() - 1)].tag);
            end
            applyStimulus(1'b0, 1'b0);
        end
        checkOutput("t4_drained", count, 0);
        checkOutput("t4_no_tag_lost", retired_total - ret_before, accepted_total - acc_before);

        // Reset in the middle of traffic clears everything at once
        $display("[TB] mid-run reset");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
        setWb(0, model_q[0].tag);
        applyStimulus(1'b0, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_count", count, 0);
        checkOutput("mid_rst_empty", empty, 1);
        checkOutput("mid_rst_cmt", cmt_valid, 0);
        #1;
        rst = 1'b1;
        model_q.delete();
        tail_tag = 0;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);

`ifdef ROB_EXCEPTION_EN
        // Excepting writeback at head: reported once, then the buffer clears
        $display("[TB] exception");
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        pc0 = int'(disp_pc);
        applyStimulus(1'b1, 1'b0);
        wb_valid = 3'b001;
        wb_rob_num[0 +: IDXW] = '0;
        wb_exc = 3'b001;
        @(posedge clk);
        #1;
        wb_valid = '0;
        wb_exc   = '0;
        checkOutput("exc_early", exc_valid, 0);
        @(posedge clk);
        #1;
        checkOutput("exc_valid", exc_valid, 1);
        checkOutput("exc_pc", exc_pc, pc0);
        checkOutput("exc_no_commit", cmt_valid, 0);
        @(posedge clk);
        #1;
        checkOutput("exc_once", exc_valid, 0);
        checkOutput("exc_count", count, 0);
        model_q.delete();
        tail_tag = 0;
`else
        pc0 = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
